// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap controller.
// Addresses, func3 encodings, interrupt cause codes and trap FSM states.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [3:0] IRQ_M_TIMER = 4'd7;
    localparam logic [3:0] IRQ_M_EXT   = 4'd11;

    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_func3_e;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } trap_state_t;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes.
// A write to either half takes precedence over the increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 64'd0;
        end else if (wr_lo) begin
            cnt_q[31:0] <= wdata;
        end else if (wr_hi) begin
            cnt_q[63:32] <= wdata;
        end else if (inc) begin
            cnt_q <= cnt_q + 64'd1;
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with interrupt entry/exit sequencing.
// Sits in EX; csr_rdata feeds writeback, trap/mret redirect fetch.
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        csr_en,
    input  logic        csr_write,
    input  logic [2:0]  csr_func3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_rs1_data,
    input  logic [4:0]  csr_zimm,
    output logic [31:0] csr_rdata,
    input  logic        mret,
    input  logic        retire,
    input  logic        stall,
    input  logic [31:0] pc_ex,
    input  logic        irq_timer,
    input  logic        irq_external,
    output logic        trap_taken,
    output logic [31:0] trap_pc,
    output logic [31:0] mret_pc
);

    logic        tmr_s1, tmr_s2;
    logic        ext_s1, ext_s2;
    logic        st_mie, st_mpie;
    logic        mie_mtie, mie_meie;
    logic [31:0] mtvec_q, mepc_q, mcause_q, mscratch_q;
    logic [31:0] mstatus_val, mie_val, mip_val;
    logic [63:0] mcycle_val, minstret_val;

    trap_state_t state_q, state_d;
    logic        irq_pend, trap_take, mret_take;
    logic [3:0]  cause_code;

    csr_func3_e  op;
    logic [31:0] src, wdata;
    logic        op_valid, do_write;

    // Two-flop synchronisers on the asynchronous interrupt lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_s1 <= 1'b0;
            tmr_s2 <= 1'b0;
            ext_s1 <= 1'b0;
            ext_s2 <= 1'b0;
        end else begin
            tmr_s1 <= irq_timer;
            tmr_s2 <= tmr_s1;
            ext_s1 <= irq_external;
            ext_s2 <= ext_s1;
        end
    end

    assign mstatus_val = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign mie_val     = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
    assign mip_val     = {20'b0, ext_s2, 3'b0, tmr_s2, 7'b0};

    assign irq_pend   = |(mie_val & mip_val);
    assign trap_take  = (state_q == RUN) & st_mie & irq_pend & ~stall & ~mret;
    assign mret_take  = (state_q == RUN) & mret;
    assign cause_code = (ext_s2 & mie_meie) ? IRQ_M_EXT : IRQ_M_TIMER;

    always_comb begin
        csr_rdata = 32'd0;
        unique case (csr_addr)
            CSR_MSTATUS:   csr_rdata = mstatus_val;
            CSR_MISA:      csr_rdata = MISA_VAL;
            CSR_MIE:       csr_rdata = mie_val;
            CSR_MTVEC:     csr_rdata = mtvec_q;
            CSR_MSCRATCH:  csr_rdata = mscratch_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MIP:       csr_rdata = mip_val;
            CSR_MCYCLE:    csr_rdata = mcycle_val[31:0];
            CSR_MCYCLEH:   csr_rdata = mcycle_val[63:32];
            CSR_MINSTRET:  csr_rdata = minstret_val[31:0];
            CSR_MINSTRETH: csr_rdata = minstret_val[63:32];
            CSR_MHARTID:   csr_rdata = HART_ID;
            default:       csr_rdata = 32'd0;
        endcase
    end

    assign op  = csr_func3_e'(csr_func3);
    assign src = csr_func3[2] ? {27'b0, csr_zimm} : csr_rs1_data;

    // Set/clear with a zero source is a pure read: no side effects
    always_comb begin
        wdata    = csr_rdata;
        op_valid = 1'b0;
        unique case (op)
            CSRRW, CSRRWI: begin
                wdata    = src;
                op_valid = 1'b1;
            end
            CSRRS, CSRRSI: begin
                wdata    = csr_rdata | src;
                op_valid = |src;
            end
            CSRRC, CSRRCI: begin
                wdata    = csr_rdata & ~src;
                op_valid = |src;
            end
            default: begin
                wdata    = csr_rdata;
                op_valid = 1'b0;
            end
        endcase
    end

    assign do_write = csr_en & csr_write & op_valid & ~trap_take;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
        end else if (trap_take) begin
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (mret_take) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (do_write && csr_addr == CSR_MSTATUS) begin
            st_mie  <= wdata[3];
            st_mpie <= wdata[7];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mie_mtie <= 1'b0;
            mie_meie <= 1'b0;
        end else if (do_write && csr_addr == CSR_MIE) begin
            mie_mtie <= wdata[7];
            mie_meie <= wdata[11];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtvec_q <= MTVEC_RESET & 32'hFFFF_FFFC;
        end else if (do_write && csr_addr == CSR_MTVEC) begin
            mtvec_q <= wdata & 32'hFFFF_FFFC;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mscratch_q <= 32'd0;
        end else if (do_write && csr_addr == CSR_MSCRATCH) begin
            mscratch_q <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mepc_q   <= 32'd0;
            mcause_q <= 32'd0;
        end else if (trap_take) begin
            mepc_q   <= pc_ex & 32'hFFFF_FFFC;
            mcause_q <= {1'b1, 27'b0, cause_code};
        end else if (do_write) begin
            if (csr_addr == CSR_MEPC) begin
                mepc_q <= wdata & 32'hFFFF_FFFC;
            end
            if (csr_addr == CSR_MCAUSE) begin
                mcause_q <= wdata;
            end
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (1'b1),
        .wr_lo   (do_write && csr_addr == CSR_MCYCLE),
        .wr_hi   (do_write && csr_addr == CSR_MCYCLEH),
        .wdata   (wdata),
        .value   (mcycle_val)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (retire),
        .wr_lo   (do_write && csr_addr == CSR_MINSTRET),
        .wr_hi   (do_write && csr_addr == CSR_MINSTRETH),
        .wdata   (wdata),
        .value   (minstret_val)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     state_d = trap_take ? TRAP : RUN;
            TRAP:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        trap_taken = (state_q == TRAP);
    end

    assign trap_pc = {mtvec_q[31:2], 2'b00};
    assign mret_pc = {mepc_q[31:2], 2'b00};

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: CSR access, counters and trap sequencing.
// Expected values are hand-computed constants.
module tb_csr_unit;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        csr_en, csr_write;
    logic [2:0]  csr_func3;
    logic [11:0] csr_addr;
    logic [31:0] csr_rs1_data;
    logic [4:0]  csr_zimm;
    logic [31:0] csr_rdata;
    logic        mret, retire, stall;
    logic [31:0] pc_ex;
    logic        irq_timer, irq_external;
    logic        trap_taken;
    logic [31:0] trap_pc, mret_pc;

    int n_checks = 0;
    int n_errs   = 0;

    csr_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .csr_en       (csr_en),
        .csr_write    (csr_write),
        .csr_func3    (csr_func3),
        .csr_addr     (csr_addr),
        .csr_rs1_data (csr_rs1_data),
        .csr_zimm     (csr_zimm),
        .csr_rdata    (csr_rdata),
        .mret         (mret),
        .retire       (retire),
        .stall        (stall),
        .pc_ex        (pc_ex),
        .irq_timer    (irq_timer),
        .irq_external (irq_external),
        .trap_taken   (trap_taken),
        .trap_pc      (trap_pc),
        .mret_pc      (mret_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        csr_addr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic rdchk(input string tag, input logic [11:0] a,
                         input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, {32'd0, d}, {32'd0, exp});
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] a,
                          input logic [31:0] v, output logic [31:0] old);
        csr_en       = 1'b1;
        csr_write    = 1'b1;
        csr_func3    = f3;
        csr_addr     = a;
        csr_rs1_data = v;
        csr_zimm     = v[4:0];
        #1;
        old = csr_rdata;
        @(posedge clk);
        #1;
        csr_en    = 1'b0;
        csr_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] old, lo, hi;

        reset_n      = 1'b0;
        csr_en       = 1'b0;
        csr_write    = 1'b0;
        csr_func3    = 3'b000;
        csr_addr     = 12'h000;
        csr_rs1_data = 32'd0;
        csr_zimm     = 5'd0;
        mret         = 1'b0;
        retire       = 1'b0;
        stall        = 1'b0;
        pc_ex        = 32'h0000_0040;
        irq_timer    = 1'b0;
        irq_external = 1'b0;

        // reset state
        tick();
        chk("rst_trap", {63'd0, trap_taken}, 64'd0);
        rdchk("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
        rdchk("rst_misa", CSR_MISA, 32'h4000_0100);
        rdchk("rst_mhartid", CSR_MHARTID, 32'd0);
        rdchk("rst_mtvec", CSR_MTVEC, 32'd0);
        rdchk("rst_mip", CSR_MIP, 32'd0);
        rdchk("rst_minstret", CSR_MINSTRET, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: mtvec write, old value returned same cycle
        csr_op(3'b001, CSR_MTVEC, 32'h8000_0103, old);
        chk("mtvec_old", {32'd0, old}, 64'd0);
        rdchk("mtvec_new", CSR_MTVEC, 32'h8000_0100);
        chk("trap_pc", {32'd0, trap_pc}, 64'h8000_0100);
        csr_op(3'b001, 12'h7C0, 32'h0000_FFFF, old);
        rdchk("unimpl_rd", 12'h7C0, 32'd0);

        // 2: external interrupt entry latency and state
        csr_op(3'b001, CSR_MIE, 32'h0000_0800, old);
        csr_op(3'b001, CSR_MSTATUS, 32'h0000_0008, old);
        rdchk("mstatus_mie", CSR_MSTATUS, 32'h0000_1808);
        irq_external = 1'b1;
        tick();
        irq_external = 1'b0;
        chk("ext_c1", {63'd0, trap_taken}, 64'd0);
        tick();
        chk("ext_c2", {63'd0, trap_taken}, 64'd0);
        tick();
        chk("ext_c3", {63'd0, trap_taken}, 64'd1);
        tick();
        chk("ext_c4", {63'd0, trap_taken}, 64'd0);
        rdchk("ext_mepc", CSR_MEPC, 32'h0000_0040);
        rdchk("ext_mcause", CSR_MCAUSE, 32'h8000_000B);
        rdchk("ext_mstatus", CSR_MSTATUS, 32'h0000_1880);

        // 3: simultaneous irqs, external wins; then MRET
        csr_op(3'b010, CSR_MIE, 32'h0000_0080, old);
        irq_timer    = 1'b1;
        irq_external = 1'b1;
        tick();
        tick();
        rdchk("both_mip", CSR_MIP, 32'h0000_0880);
        chk("both_nomie", {63'd0, trap_taken}, 64'd0);
        csr_op(3'b001, CSR_MSTATUS, 32'h0000_0008, old);
        tick();
        chk("both_trap", {63'd0, trap_taken}, 64'd1);
        rdchk("both_mcause", CSR_MCAUSE, 32'h8000_000B);
        irq_timer    = 1'b0;
        irq_external = 1'b0;
        tick();
        mret = 1'b1;
        #1;
        chk("mret_pc", {32'd0, mret_pc}, 64'h0000_0040);
        tick();
        mret = 1'b0;
        rdchk("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
        tick();
        chk("mret_notrap", {63'd0, trap_taken}, 64'd0);

        // 4: counter write, wrap and zero-source set/clear
        csr_op(3'b001, CSR_MCYCLE, 32'hFFFF_FFFF, old);
        csr_op(3'b001, CSR_MCYCLEH, 32'hFFFF_FFFF, old);
        tick();
        tick();
        rd(CSR_MCYCLE, lo);
        rd(CSR_MCYCLEH, hi);
        chk("mcycle_wrap", {hi, lo}, 64'd1);
        csr_op(3'b010, CSR_MCYCLE, 32'd0, old);
        rd(CSR_MCYCLE, lo);
        chk("csrrs_x0", {32'd0, lo}, {32'd0, old + 32'd1});
        csr_op(3'b111, CSR_MCYCLE, 32'd0, old);
        rd(CSR_MCYCLE, lo);
        chk("csrrci_0", {32'd0, lo}, {32'd0, old + 32'd1});
        retire = 1'b1;
        tick();
        tick();
        tick();
        retire = 1'b0;
        rdchk("minstret", CSR_MINSTRET, 32'd3);

        // 5: stall blocks trap; trap suppresses same-cycle write
        stall     = 1'b1;
        irq_timer = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", {63'd0, trap_taken}, 64'd0);
        end
        stall = 1'b0;
        csr_op(3'b001, CSR_MSCRATCH, 32'h0000_1234, old);
        chk("sup_trap", {63'd0, trap_taken}, 64'd1);
        rdchk("sup_mscratch", CSR_MSCRATCH, 32'd0);
        rdchk("tmr_mcause", CSR_MCAUSE, 32'h8000_0007);
        irq_timer = 1'b0;
        tick();
        csr_op(3'b001, CSR_MSCRATCH, 32'h0000_1200, old);
        csr_op(3'b110, CSR_MSCRATCH, 32'h0000_0005, old);
        csr_op(3'b011, CSR_MSCRATCH, 32'h0000_1000, old);
        rdchk("rs_rc", CSR_MSCRATCH, 32'h0000_0205);

        // 6: reset in the middle of TRAP
        irq_external = 1'b1;
        tick();
        tick();
        csr_op(3'b010, CSR_MSTATUS, 32'h0000_0008, old);
        tick();
        chk("pre_rst_trap", {63'd0, trap_taken}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_trap", {63'd0, trap_taken}, 64'd0);
        rdchk("rst_mepc", CSR_MEPC, 32'd0);
        irq_external = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("post_rst_trap", {63'd0, trap_taken}, 64'd0);
        rdchk("post_rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
        csr_op(3'b001, CSR_MSCRATCH, 32'h0000_0055, old);
        rdchk("post_rst_wr", CSR_MSCRATCH, 32'h0000_0055);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
